// File: rtl/fetch_unit_if.sv
// Fetch-stage / fetch-unit bus, including the instruction-cache refill port.
// master: the fetch stage plus the memory side; slave: fetch_unit.
interface fetch_unit_if #(
  parameter int LINE_WIDTH = 128
);
  // Request side from the fetch and execute stages
  logic [31:0]           nextPc;
  logic                  flush;
  logic                  stall;
  logic                  invalidateICache;
  logic                  invalidateTlb;
  // Registered fetch result
  logic                  valid;
  logic                  fault;
  logic [31:0]           pc;
  logic [LINE_WIDTH-1:0] iCacheLine;
  // Refill port: memReadReq/memAddr are held stable until a cycle with
  // memReadGrant=1 completes the request; the memory then returns exactly one
  // memReadValid beat carrying memReadData. Only one refill is outstanding.
  logic                  memReadReq;
  logic [31:0]           memAddr;
  logic                  memReadGrant;
  logic                  memReadValid;
  logic [LINE_WIDTH-1:0] memReadData;

  modport master (
    output nextPc, flush, stall, invalidateICache, invalidateTlb,
    output memReadGrant, memReadValid, memReadData,
    input  valid, fault, pc, iCacheLine, memReadReq, memAddr
  );

  modport slave (
    input  nextPc, flush, stall, invalidateICache, invalidateTlb,
    input  memReadGrant, memReadValid, memReadData,
    output valid, fault, pc, iCacheLine, memReadReq, memAddr
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: direct-mapped, physically addressed instruction cache with a
// single-outstanding line refill port and a registered fetch result.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h8000_0000,
  parameter int          LINE_WIDTH   = 128,
  parameter int          INDEX_WIDTH  = 6,
  parameter int          OFFSET_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rstN,
  fetch_unit_if.slave  fu,
  output logic [1:0]   state_dbg
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 32 - OFFSET_WIDTH - INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_INVALIDATE = 2'd0,
    ST_LOOKUP     = 2'd1,
    ST_MISS_REQ   = 2'd2,
    ST_MISS_WAIT  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [31:0]             req_pc_q;
  logic [31:0]             miss_addr_q;
  logic [INDEX_WIDTH-1:0]  sweep_q;
  logic                    pending_inv_q;
  logic                    valid_q;
  logic                    fault_q;
  logic [31:0]             pc_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic                    mem_req_q;

  // Cache arrays; only the valid bits need a reset value
  logic [LINES-1:0]        line_valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [LINE_WIDTH-1:0]   data_mem [LINES];

  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_WIDTH-1:0]  miss_idx;
  logic [TAG_W-1:0]        miss_tag;
  logic                    hit;
  logic                    misaligned;
  logic                    unused_tlb;

  assign req_idx    = req_pc_q[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign req_tag    = req_pc_q[31:OFFSET_WIDTH+INDEX_WIDTH];
  assign miss_idx   = miss_addr_q[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign miss_tag   = miss_addr_q[31:OFFSET_WIDTH+INDEX_WIDTH];
  assign hit        = line_valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign misaligned = |req_pc_q[1:0];

  // No TLB in a physically addressed fetch path; the pulse is accepted and dropped
  assign unused_tlb = fu.invalidateTlb;

  assign fu.valid      = valid_q;
  assign fu.fault      = fault_q;
  assign fu.pc         = pc_q;
  assign fu.iCacheLine = line_q;
  assign fu.memReadReq = mem_req_q;
  assign fu.memAddr    = miss_addr_q;
  assign state_dbg     = state_q;

  // Refill write of tag and data; the matching valid bit is set by the FSM
  always_ff @(posedge clk) begin
    if (state_q == ST_MISS_WAIT && fu.memReadValid) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= fu.memReadData;
    end
  end

  // Control FSM: invalidate sweep, lookup, refill request and refill wait
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= ST_INVALIDATE;
      req_pc_q      <= RESET_PC;
      miss_addr_q   <= '0;
      sweep_q       <= '0;
      pending_inv_q <= 1'b0;
      valid_q       <= 1'b0;
      fault_q       <= 1'b0;
      pc_q          <= '0;
      line_q        <= '0;
      mem_req_q     <= 1'b0;
      line_valid_q  <= '0;
    end else begin
      case (state_q)
        ST_INVALIDATE: begin
          valid_q <= 1'b0;
          if (fu.flush) req_pc_q <= fu.nextPc;
          if (fu.invalidateICache) begin
            // A fresh invalidate restarts the sweep from line 0
            sweep_q <= '0;
          end else begin
            line_valid_q[sweep_q] <= 1'b0;
            sweep_q               <= sweep_q + 1'b1;
            if (sweep_q == '1) state_q <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (fu.invalidateICache) begin
            valid_q <= 1'b0;
            sweep_q <= '0;
            state_q <= ST_INVALIDATE;
            if (fu.flush) req_pc_q <= fu.nextPc;
          end else if (fu.flush) begin
            valid_q  <= 1'b0;
            req_pc_q <= fu.nextPc;
          end else if (fu.stall) begin
            // Hold request and outputs bit-stable
            valid_q <= valid_q;
          end else if (misaligned) begin
            valid_q  <= 1'b1;
            fault_q  <= 1'b1;
            pc_q     <= req_pc_q;
            line_q   <= '0;
            req_pc_q <= fu.nextPc;
          end else if (hit) begin
            valid_q  <= 1'b1;
            fault_q  <= 1'b0;
            pc_q     <= req_pc_q;
            line_q   <= data_mem[req_idx];
            req_pc_q <= fu.nextPc;
          end else begin
            valid_q     <= 1'b0;
            miss_addr_q <= {req_pc_q[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            mem_req_q   <= 1'b1;
            state_q     <= ST_MISS_REQ;
          end
        end

        ST_MISS_REQ: begin
          if (fu.flush)            req_pc_q      <= fu.nextPc;
          if (fu.invalidateICache) pending_inv_q <= 1'b1;
          if (fu.memReadGrant) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_MISS_WAIT;
          end
        end

        ST_MISS_WAIT: begin
          if (fu.flush)            req_pc_q      <= fu.nextPc;
          if (fu.invalidateICache) pending_inv_q <= 1'b1;
          if (fu.memReadValid) begin
            line_valid_q[miss_idx] <= 1'b1;
            if (pending_inv_q || fu.invalidateICache) begin
              pending_inv_q <= 1'b0;
              sweep_q       <= '0;
              state_q       <= ST_INVALIDATE;
            end else begin
              state_q <= ST_LOOKUP;
            end
          end
        end

        default: state_q <= ST_INVALIDATE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Responder side of the fetch-stage/fetch-unit interface: accepts the next PC, flush and stall from the fetch stage and cache-invalidate requests from the execute stage, and returns a registered valid/fault/pc/instruction-cache-line result. It contains a direct-mapped instruction cache with tag, valid and data arrays, and a single-outstanding line-refill port to the memory side. Addressing is physical. `invalidateTlb` is accepted for interface compatibility and has no effect.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- LINE_WIDTH, 128, cache line width in bits (matches icache_line_t)
- INDEX_WIDTH, 6, log2 of line count (64 lines)
- OFFSET_WIDTH, 4, byte offset bits within a line
- clk  in  1  clock; all state changes on rising edge
- rstN  in  1  asynchronous, active-low reset
- nextPc  in  32  fetch address for the next request
- flush  in  1  discard the current request and output; restart at nextPc
- stall  in  1  hold outputs and the current request
- invalidateICache  in  1  single-cycle pulse: clear all valid bits
- invalidateTlb  in  1  ignored
- valid  out  1  output result is valid
- fault  out  1  result is a fetch fault (pc[1:0] != 0)
- pc  out  32  address of the result
- iCacheLine  out  LINE_WIDTH  line containing pc; 0 when fault=1
- memReadReq  out  1  refill request; held until granted
- memAddr  out  32  line-aligned refill address (low OFFSET_WIDTH bits = 0)
- memReadGrant  in  1  request accepted this cycle
- memReadValid  in  1  refill data valid (exactly one beat per grant)
- memReadData  in  LINE_WIDTH  refill line

## Operation
- Registers: reqPc (current lookup address), missAddr, sweep counter, pendingInv, state, output registers.
- States: INVALIDATE, LOOKUP, MISS_REQ, MISS_WAIT.
- Reset: state=INVALIDATE, counter=0, reqPc=RESET_PC. Outputs: valid=0, fault=0, pc=0, iCacheLine=0, memReadReq=0, memAddr=0. pendingInv=0.
- INVALIDATE: clears valid[counter] each cycle and counter increments. The counter wraps at 2^INDEX_WIDTH, then state goes to LOOKUP. valid=0 throughout.
- LOOKUP, priority order:
  - flush: valid<=0; reqPc<=nextPc.
  - stall: hold everything.
  - Misaligned reqPc: valid=1, fault=1, pc=reqPc, line=0; reqPc<=nextPc.
  - Hit (valid bit set and tag match at reqPc index): valid=1, fault=0, pc=reqPc, line=data; reqPc<=nextPc.
  - Miss: valid<=0; missAddr<=reqPc line-aligned; go to MISS_REQ.
- MISS_REQ: memReadReq=1, memAddr=missAddr. On memReadGrant, go to MISS_WAIT. The request is never retracted.
- MISS_WAIT: on memReadValid, write the data, tag and valid bit at the missAddr index, then go to LOOKUP, or to INVALIDATE if pendingInv is set (this clears pendingInv).
- flush in MISS_REQ/MISS_WAIT: reqPc<=nextPc; valid stays 0; the refill still completes with missAddr.
- stall in MISS_*: has no effect on the refill.
- invalidateICache:
  - In LOOKUP: go to INVALIDATE next cycle; valid<=0. Any flush in the same cycle still updates reqPc.
  - In MISS_*: sets pendingInv.
  - In INVALIDATE: the sweep restarts at 0.
- Tag = addr[31:OFFSET_WIDTH+INDEX_WIDTH]; index = addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH].

## Timing
- Hit: a lookup at edge N produces valid/pc/iCacheLine registered at edge N+1. Back-to-back hits sustain 1 result per cycle.
- Miss: miss detected at edge N. memReadReq is high from N+1 until grant. The refill is written on the edge where memReadValid=1 (edge M), LOOKUP hits at M+1, and valid=1 at M+1.
- Invalidate sweep: 2^INDEX_WIDTH cycles (64). The first lookup happens on the cycle after the last clear.
- With stall=1 and no flush, all outputs are bit-stable.
- Asserting rstN low mid-miss returns all outputs to their reset values immediately. A late memReadValid after reset is ignored; the memory side is reset together with this block.

## Test plan
- Reset release -> valid=0 for 64 cycles, memReadReq=0; then a miss request with memAddr=0x8000_0000.
- Cold miss at 0x8000_0000, grant after 2 cycles, data 0x0123..CDEF after 3 more -> next cycle valid=1, pc=0x8000_0000, iCacheLine=0x0123..CDEF, fault=0.
- Sequential fetch 0x8000_0004, 0x8000_0008 after the refill -> valid on consecutive cycles, no memReadReq, same line returned.
- nextPc=0x8000_0102 -> valid=1, fault=1, pc=0x8000_0102, iCacheLine=0, no memory request.
- flush with nextPc=0x8000_1000 during MISS_WAIT for 0x8000_0040:
  - The refill completes; the next request is memAddr=0x8000_1000.
  - A later fetch of 0x8000_0040 hits.
- invalidateICache pulse after the lines are filled, plus a stall held for 5 cycles during hits:
  - The invalidate gives a 64-cycle sweep, then a refetch of 0x8000_0000 misses.
  - During the stall, outputs are unchanged.
